mac_array_ctrl: RTL and testbench

Sequencer for the SIMD MAC array. Accepts a byte stream from the host link: one command byte, then num_MAC A operands, then num_MAC B operands. It loads the A and B operands into registered operand vectors and drives the array mode. It then waits a programmable settle time for the combinational MAC chain, captures the array output, and streams the result back as bytes. It sits between the host byte interface and the MAC array; the array itself stays purely combinational.

---
 rtl/mac_array_ctrl_if.sv | 24 ++
 rtl/mac_array_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mac_array_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_ctrl_if.sv
// Host byte-stream link for the MAC array sequencer.
// Carries one command/operand byte stream toward the controller and one
// result byte stream back to the host, each with a valid/ready handshake.
//   in_data/in_valid/in_ready    : host -> controller bytes
//   out_data/out_valid/out_ready : controller -> host result bytes
// master = host side, slave = controller side.
interface mac_array_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mac_array_ctrl.sv
// Sequencer for the SIMD MAC array.
// Takes a command byte, num_MAC A bytes and num_MAC B bytes from the host
// stream, holds them in registered operand vectors, waits SETTLE cycles for
// the combinational MAC chain, captures mac_dout and streams it back.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   clr       : synchronous abort to IDLE (operands/results kept)
//   host      : byte stream link (slave side)
//   mode      : array mode, latched from command byte
//   din_a/b   : registered operand vectors to the array
//   mac_dout  : array output, sampled in CAPTURE only
//   busy      : high outside IDLE
//   done      : one-cycle pulse on entry to IDLE after the last result byte
//
// state     | meaning
// ----------+------------------------------------------------------
// S_IDLE    | waiting for command byte
// S_LOAD_A  | accepting A operand bytes, lane 0 first
// S_LOAD_B  | accepting B operand bytes, lane 0 first
// S_SETTLE  | counting down while the MAC chain settles
// S_CAPTURE | registering mac_dout into the result register
// S_SEND    | streaming result bytes to the host
module mac_array_ctrl #(
  parameter int bw      = 8,
  parameter int num_MAC = 32,
  parameter int SETTLE  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  mac_array_ctrl_if.slave         host,
  output logic [1:0]              mode,
  output logic [bw*num_MAC-1:0]   din_a,
  output logic [bw*num_MAC-1:0]   din_b,
  input  logic [bw*num_MAC-1:0]   mac_dout,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = $clog2(num_MAC);
  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [IW-1:0] LAST = IW'(num_MAC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_SETTLE,
    S_CAPTURE,
    S_SEND
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 all_q, all_d;
  logic [1:0]           mode_q, mode_d;
  logic                 done_q, done_d;
  logic [bw*num_MAC-1:0] res_q;
  logic                 wr_a, wr_b, cap;
  logic                 in_rdy, out_vld;
  logic                 in_xfer, out_xfer;

  // in_ready is a pure state decode, but it is also forced low while the
  // reset pin is asserted so the host sees "not ready" during reset.
  assign in_rdy   = rst && (state_q == S_IDLE || state_q == S_LOAD_A ||
                            state_q == S_LOAD_B);
  assign out_vld  = (state_q == S_SEND);
  assign in_xfer  = host.in_valid && in_rdy;
  assign out_xfer = out_vld && host.out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    all_d   = all_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
    cap     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_xfer) begin
          mode_d  = host.in_data[1:0];
          all_d   = host.in_data[2];
          idx_d   = '0;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        if (in_xfer) begin
          wr_a = 1'b1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (in_xfer) begin
          wr_b = 1'b1;
          if (idx_q == LAST) begin
            cnt_d   = CW'(SETTLE - 1);
            state_d = S_SETTLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        cap     = 1'b1;
        idx_d   = all_q ? '0 : LAST;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_xfer) begin
          if (idx_q == LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything: the byte in flight is dropped and no
    // register other than the counters/state is touched.
    if (clr) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      all_d   = all_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      wr_a    = 1'b0;
      wr_b    = 1'b0;
      cap     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      all_q   <= 1'b0;
      mode_q  <= '0;
      done_q  <= 1'b0;
      din_a   <= '0;
      din_b   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      all_q   <= all_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      if (wr_a) din_a[idx_q*bw +: bw] <= host.in_data;
      if (wr_b) din_b[idx_q*bw +: bw] <= host.in_data;
      if (cap)  res_q <= mac_dout;
    end
  end

  assign host.in_ready  = in_rdy;
  assign host.out_valid = out_vld;
  assign host.out_data  = out_vld ? res_q[idx_q*bw +: bw] : '0;
  assign mode           = mode_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
module tb_mac_array_ctrl;
  localparam int NM = 32;
  localparam int ST = 4;
  localparam int W  = 8 * NM;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic [1:0]   mode;
  logic [W-1:0] din_a, din_b, mac_dout;
  logic         busy, done;

  mac_array_ctrl_if bus();

  mac_array_ctrl #(.bw(8), .num_MAC(NM), .SETTLE(ST)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .host     (bus),
    .mode     (mode),
    .din_a    (din_a),
    .din_b    (din_b),
    .mac_dout (mac_dout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  logic [7:0]   a_bytes [NM];
  logic [7:0]   b_bytes [NM];
  logic [7:0]   lanes   [NM];
  logic [7:0]   expq [$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pack(input logic [7:0] v [NM]);
    logic [W-1:0] r;
    for (int i = 0; i < NM; i++) r[i*8 +: 8] = v[i];
    return r;
  endfunction

  // Expected result stream: all lanes in order, or just the chain end.
  task automatic build_exp(input logic all);
    expq.delete();
    if (all) for (int i = 0; i < NM; i++) expq.push_back(lanes[i]);
    else     expq.push_back(lanes[NM-1]);
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int g, n;
    g = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
    repeat (g) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      step();
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("in_ready", W'(bus.in_ready), W'(1));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_operands(input int maxgap);
    for (int i = 0; i < NM; i++) send_byte(a_bytes[i], maxgap);
    for (int i = 0; i < NM; i++) send_byte(b_bytes[i], maxgap);
  endtask

  // Returns number of cycles from the negedge after the last B transfer to
  // first out_valid. With garble, lanes are random until the CAPTURE cycle
  // (SETTLE cycles after that negedge) and 8'h5A from there on.
  task automatic settle_phase(input logic garble, output int lat);
    int k;
    k = 0;
    while (bus.out_valid !== 1'b1 && k < 40) begin
      if (garble) begin
        if (k < ST) mac_dout = {8{$urandom}};
        else        mac_dout = {NM{8'h5A}};
      end
      step();
      k++;
    end
    lat = k;
  endtask

  task automatic recv(input int maxstall);
    int s, n;
    logic [7:0] held;
    while (expq.size() > 0) begin
      s = (maxstall > 0) ? $urandom_range(maxstall, 0) : 0;
      bus.out_ready = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 50) begin step(); n++; end
      held = bus.out_data;
      repeat (s) begin
        step();
        chk("stall_valid", W'(bus.out_valid), W'(1));
        chk("stall_hold", W'(bus.out_data), W'(held));
      end
      bus.out_ready = 1'b1;
      chk("out_valid", W'(bus.out_valid), W'(1));
      chk("out_byte", W'(bus.out_data), W'(expq.pop_front()));
      step();
      bus.out_ready = 1'b0;
    end
    chk("done_pulse", W'(done), W'(1));
    chk("idle_after", W'(busy), W'(0));
    step();
    chk("done_low", W'(done), W'(0));
  endtask

  initial begin
    int lat, d0;
    logic [7:0]   cmd;
    logic [W-1:0] exp_b;

    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NM; i++) lanes[i] = 8'hA0 + 8'(i);
    mac_dout = pack(lanes);

    #3;
    chk("rst_in_ready", W'(bus.in_ready), W'(0));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_out_data", W'(bus.out_data), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_mode", W'(mode), W'(0));
    chk("rst_din_a", din_a, '0);
    chk("rst_din_b", din_b, '0);
    #9 rst = 1'b1;
    step();
    chk("idle_in_ready", W'(bus.in_ready), W'(1));
    chk("idle_busy", W'(busy), W'(0));

    // Job 1: ALL=1, mode 0, ramp operands
    for (int i = 0; i < NM; i++) begin
      a_bytes[i] = 8'(i);
      b_bytes[i] = 8'(32 + i);
    end
    d0 = done_cnt;
    send_byte(8'h04, 0);
    send_operands(0);
    settle_phase(1'b0, lat);
    build_exp(1'b1);
    recv(0);
    step();
    chk("j1_din_a_lo", W'(din_a[7:0]), W'(0));
    chk("j1_din_a_hi", W'(din_a[255:248]), W'(31));
    chk("j1_din_b_hi", W'(din_b[255:248]), W'(63));
    chk("j1_din_a", din_a, pack(a_bytes));
    chk("j1_din_b", din_b, pack(b_bytes));
    chk("j1_done_once", W'(done_cnt - d0), W'(1));

    // Job 2: ALL=0, mode 3, latency check
    d0 = done_cnt;
    send_byte(8'h03, 0);
    chk("j2_mode", W'(mode), W'(3));
    send_operands(0);
    settle_phase(1'b0, lat);
    // Last B transfer is cycle T; first out_valid is cycle T+SETTLE+2,
    // i.e. SETTLE+1 cycles after the sampling point right after T.
    chk("j2_latency", W'(lat), W'(ST + 1));
    build_exp(1'b0);
    recv(0);
    step();
    chk("j2_mode_held", W'(mode), W'(3));
    chk("j2_idle", W'(busy), W'(0));
    chk("j2_done_once", W'(done_cnt - d0), W'(1));

    // Randomised jobs with input gaps and output stalls
    for (int j = 0; j < 4; j++) begin
      cmd = 8'($urandom);
      for (int i = 0; i < NM; i++) begin
        a_bytes[i] = 8'($urandom);
        b_bytes[i] = 8'($urandom);
        lanes[i]   = 8'($urandom);
      end
      mac_dout = pack(lanes);
      d0 = done_cnt;
      send_byte(cmd, 3);
      send_operands(3);
      settle_phase(1'b0, lat);
      build_exp(cmd[2]);
      recv(3);
      step();
      chk("rnd_mode", W'(mode), W'(cmd[1:0]));
      chk("rnd_din_a", din_a, pack(a_bytes));
      chk("rnd_din_b", din_b, pack(b_bytes));
      chk("rnd_done_once", W'(done_cnt - d0), W'(1));
    end

    // mac_dout moving during SETTLE; only the CAPTURE-cycle value counts
    for (int i = 0; i < NM; i++) begin
      a_bytes[i] = 8'($urandom);
      b_bytes[i] = 8'($urandom);
      lanes[i]   = 8'h5A;
    end
    send_byte(8'h04, 0);
    send_operands(0);
    settle_phase(1'b1, lat);
    build_exp(1'b1);
    recv(2);
    step();
    exp_b = pack(b_bytes);

    // clr in LOAD_B at idx=10 together with an offered byte
    for (int i = 0; i < NM; i++) begin
      a_bytes[i] = 8'($urandom);
      b_bytes[i] = 8'($urandom);
    end
    d0 = done_cnt;
    send_byte(8'h05, 0);
    for (int i = 0; i < NM; i++) send_byte(a_bytes[i], 0);
    for (int i = 0; i < 10; i++) begin
      send_byte(b_bytes[i], 0);
      exp_b[i*8 +: 8] = b_bytes[i];
    end
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h06;
    step();
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_idle", W'(busy), W'(0));
    chk("clr_in_ready", W'(bus.in_ready), W'(1));
    chk("clr_dropped", din_b, exp_b);
    chk("clr_mode", W'(mode), W'(1));
    chk("clr_no_done", W'(done_cnt - d0), W'(0));

    for (int i = 0; i < NM; i++) begin
      a_bytes[i] = 8'($urandom);
      b_bytes[i] = 8'($urandom);
      lanes[i]   = 8'($urandom);
    end
    mac_dout = pack(lanes);
    d0 = done_cnt;
    send_byte(8'h02, 1);
    chk("post_clr_mode", W'(mode), W'(2));
    send_operands(1);
    settle_phase(1'b0, lat);
    build_exp(1'b0);
    recv(1);
    step();
    chk("post_clr_din_a", din_a, pack(a_bytes));
    chk("post_clr_din_b", din_b, pack(b_bytes));
    chk("post_clr_done", W'(done_cnt - d0), W'(1));

    // rst in the middle of SEND
    send_byte(8'h07, 0);
    send_operands(0);
    settle_phase(1'b0, lat);
    bus.out_ready = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", W'(bus.in_ready), W'(0));
    chk("arst_out_valid", W'(bus.out_valid), W'(0));
    chk("arst_out_data", W'(bus.out_data), W'(0));
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_done", W'(done), W'(0));
    chk("arst_mode", W'(mode), W'(0));
    chk("arst_din_a", din_a, '0);
    chk("arst_din_b", din_b, '0);
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    step();
    chk("arst_release", W'(bus.in_ready), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
